systolic_ctrl: RTL and testbench
================================

# systolic_ctrl

Sequencing controller for the N×N weight-accumulating PE array. On a `start` request it clears the array, streams skewed A rows and B columns from the edge buffers into the array for the exact number of cycles needed, then drains the N result rows to a downstream consumer under a valid/ready handshake. It sits between the host command interface, the A/B edge buffers and the PE array. It owns every array-level control signal: array reset, accumulate enable and edge-data gating.

## Interface
- `N`, 4: array dimension (rows = columns = N), ≥2.
- `KMAX`, 16: maximum inner dimension K, ≥1.
- `KW`, $clog2(KMAX): edge-buffer address width; `k_len` is KW+1 bits.
- `clk`  in  1  clock; all logic on rising edge.
- `rstn`  in  1  reset: `rstn`, synchronous, active-low; clock `clk`.
- `start`  in  1  job request; sampled only in IDLE.
- `k_len`  in  KW+1  inner dimension K for the job; sampled with `start`.
- `busy`  out  1  high from the cycle after accepted start until DONE completes.
- `done`  out  1  one-cycle completion pulse.
- `err`  out  1  one-cycle pulse when a start is rejected.
- `arr_rstn`  out  1  synchronous active-low reset to every PE.
- `pe_en`  out  1  accumulate enable, broadcast to every PE.
- `a_valid`  out  N  per-row edge valid; edge mux drives 0 into the array when low.
- `a_addr`  out  N*KW  per-row A buffer address; lane i occupies bits [i*KW +: KW].
- `b_valid`  out  N  per-column edge valid.
- `b_addr`  out  N*KW  per-column B buffer address.
- `res_row`  out  $clog2(N)  row select for the result readout mux.
- `res_valid`  out  1  the selected result row is valid.
- `res_ready`  in  1  consumer accepts the row.

## Operation
- States: IDLE → CLEAR → FEED → DRAIN → DONE → IDLE.
- **IDLE**
  - On `start` with 1 ≤ `k_len` ≤ KMAX: latch K and go to CLEAR.
  - On `start` with `k_len` = 0 or `k_len` > KMAX: pulse `err` and stay in IDLE.
- **CLEAR** (1 cycle): `arr_rstn` = 0, which zeroes the PE accumulators and forwarding registers.
- **FEED**: runs for F = K + 2N − 2 cycles, counted by feed counter t = 0..F−1. `pe_en` = 1 for the whole state.
  - Row lane i: `a_valid[i]` = (i ≤ t < i+K), `a_addr[i]` = t − i when valid, else 0.
  - Column lane j: same rule with j.
  - With this skew, element k meets PE(i,j) at t = i + j + k. Zeros outside the window add nothing to the accumulators.
- **DRAIN**
  - `res_valid` = 1 and `res_row` = r, with r starting at 0.
  - r increments only on `res_valid` && `res_ready`.
  - After the transfer of row N−1, go to DONE.
  - `pe_en` = 0, so results hold while the consumer stalls.
- **DONE** (1 cycle): `done` = 1, `busy` = 0, then IDLE.
- `start` outside IDLE is ignored; it is neither queued nor flagged with `err`.
- Array dataflow contract: PE forwarding registers add one cycle per hop, and edge buffers read combinationally from the registered address.

## Timing
- All outputs are registered.
- Reset values: `arr_rstn` = 0, `busy` = `done` = `err` = `pe_en` = `res_valid` = 0, all valids/addresses/`res_row` = 0, state = IDLE.
- `arr_rstn` is 1 in every cycle except CLEAR and reset.
- Cycle-level sequence:
  - Start accepted at cycle c.
  - CLEAR at c+1.
  - FEED at c+2 … c+F+1.
  - First DRAIN cycle c+F+2.
- Latency from start to first `res_valid` is F+2 cycles.
- With `res_ready` held high, DRAIN lasts N cycles, and `done` asserts at c+F+N+2.
- Reset mid-job: the next cycle is IDLE with all outputs at reset values, and the array is held in reset (`arr_rstn` = 0).
- K = 1 is legal: F = 2N − 1.
- K = KMAX is legal: the maximum address is KMAX − 1, and the feed counter never wraps.
- Feed counter width: $clog2(KMAX + 2N − 1).

## Structure
- Package `systolic_pkg`:
  - state enum `ctrl_state_t` (IDLE, CLEAR, FEED, DRAIN, DONE);
  - width helper constants for the feed counter and row index.
- Sub-module `systolic_skew_lane`: computes one lane's valid and address from t, the lane index and K. Instantiated N times for A and N times for B.
- The FSM, feed counter and drain counter stay in `systolic_ctrl`.

## Test plan
- N=4, K=3, start at cycle 0, `res_ready` = 1:
  - `arr_rstn` low at cycle 1 only;
  - `pe_en` high for cycles 2–10 (9 cycles);
  - `res_row` 0..3 on cycles 11–14;
  - `done` at cycle 15.
- Same job, checking lanes: `a_valid[2]` high exactly at t = 2..4 with `a_addr[2]` = 0,1,2; `b_valid[0]` high at t = 0..2.
- `res_ready` low for 3 cycles during row 1: `res_row` holds at 1, `res_valid` stays high, `pe_en` stays 0, and `done` is delayed by 3 cycles.
- Start with `k_len` = 0, then with `k_len` = 17 (KMAX = 16): `err` pulses once each, `busy` stays 0.
- `start` asserted during FEED: no effect on counters, and exactly one `done`.
- `rstn` low for one cycle at t = 4 of FEED: next cycle IDLE with all outputs at reset values; a new start then completes normally.

Source files
------------

// File: rtl/systolic_pkg.sv
// Shared types and width helpers for the systolic array sequencing controller.
package systolic_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    FEED,
    DRAIN,
    DONE
  } ctrl_state_t;

  // The feed counter must reach K + 2N - 2 distinct values without wrapping at K = KMAX.
  function automatic int feedCntWidth(input int kmax, input int n);
    return $clog2(kmax + 2 * n - 1);
  endfunction

  function automatic int rowIdxWidth(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/systolic_ctrl_if.sv
// Host command, array control and result handshake bundle for systolic_ctrl.
interface systolic_ctrl_if
  import systolic_pkg::*;
#(
  parameter int N    = 4,
  parameter int KMAX = 16
);
  localparam int KW = $clog2(KMAX);
  localparam int RW = rowIdxWidth(N);

  logic            start;
  logic [KW:0]     k_len;
  logic            busy;
  logic            done;
  logic            err;
  logic            arr_rstn;
  logic            pe_en;
  logic [N-1:0]    a_valid;
  logic [N*KW-1:0] a_addr;
  logic [N-1:0]    b_valid;
  logic [N*KW-1:0] b_addr;
  logic [RW-1:0]   res_row;
  logic            res_valid;
  logic            res_ready;

  modport master (
    input  start, k_len, res_ready,
    output busy, done, err, arr_rstn, pe_en,
    output a_valid, a_addr, b_valid, b_addr,
    output res_row, res_valid
  );

  modport slave (
    output start, k_len, res_ready,
    input  busy, done, err, arr_rstn, pe_en,
    input  a_valid, a_addr, b_valid, b_addr,
    input  res_row, res_valid
  );

endinterface

// File: rtl/systolic_skew_lane.sv
// One edge lane of the skewed feed: valid while LANE <= t < LANE + K, address t - LANE.
module systolic_skew_lane #(
  parameter int KW   = 4,
  parameter int TW   = 5,
  parameter int LANE = 0
) (
  input  logic [TW-1:0] i_t,
  input  logic [KW:0]   i_k,
  input  logic          i_en,
  output logic          o_valid,
  output logic [KW-1:0] o_addr
);
  // Two spare bits keep LANE + K from overflowing for any legal K.
  localparam int LW = TW + 2;

  logic [LW-1:0] w_t;
  logic [LW-1:0] w_lo;
  logic [LW-1:0] w_hi;

  assign w_t  = LW'(i_t);
  assign w_lo = LW'(LANE);
  assign w_hi = w_lo + LW'(i_k);

  assign o_valid = i_en && (w_t >= w_lo) && (w_t < w_hi);
  assign o_addr  = o_valid ? KW'(w_t - w_lo) : '0;

endmodule

// File: rtl/systolic_ctrl.sv
// Sequencer for the NxN PE array: clear, skewed edge feed, then handshaked row drain.
module systolic_ctrl
  import systolic_pkg::*;
#(
  parameter int N    = 4,
  parameter int KMAX = 16
) (
  input  logic            clk,
  input  logic            rstn,
  systolic_ctrl_if.master bus
);
  localparam int KW = $clog2(KMAX);
  localparam int TW = feedCntWidth(KMAX, N);
  localparam int RW = rowIdxWidth(N);

  localparam logic [KW:0]   C_KMAX     = (KW + 1)'(KMAX);
  localparam logic [TW-1:0] C_SKEW     = TW'(2 * N - 3);
  localparam logic [RW-1:0] C_LAST_ROW = RW'(N - 1);

  ctrl_state_t     r_state;
  ctrl_state_t     w_stateNext;
  logic [KW:0]     r_k;
  logic [KW:0]     w_kNext;
  logic [TW-1:0]   r_t;
  logic [TW-1:0]   w_tNext;
  logic [TW-1:0]   w_tLast;
  logic [RW-1:0]   r_row;
  logic [RW-1:0]   w_rowNext;
  logic            w_errNext;
  logic            w_kOk;
  logic            w_feedNext;

  logic            r_busy;
  logic            r_done;
  logic            r_err;
  logic            r_arrRstn;
  logic            r_peEn;
  logic            r_resValid;
  logic [N-1:0]    r_aValid;
  logic [N-1:0]    r_bValid;
  logic [N*KW-1:0] r_aAddr;
  logic [N*KW-1:0] r_bAddr;
  logic [N-1:0]    w_aValid;
  logic [N-1:0]    w_bValid;
  logic [N*KW-1:0] w_aAddr;
  logic [N*KW-1:0] w_bAddr;

  assign w_kOk      = (bus.k_len != '0) && (bus.k_len <= C_KMAX);
  assign w_tLast    = TW'(r_k) + C_SKEW;
  assign w_feedNext = (w_stateNext == FEED);

  always_comb begin
    w_stateNext = r_state;
    w_kNext     = r_k;
    w_tNext     = r_t;
    w_rowNext   = r_row;
    w_errNext   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (bus.start) begin
          if (w_kOk) begin
            w_stateNext = CLEAR;
            w_kNext     = bus.k_len;
          end else begin
            w_errNext = 1'b1;
          end
        end
      end
      CLEAR: begin
        w_stateNext = FEED;
        w_tNext     = '0;
      end
      FEED: begin
        if (r_t == w_tLast) begin
          w_stateNext = DRAIN;
          w_rowNext   = '0;
        end else begin
          w_tNext = r_t + TW'(1);
        end
      end
      DRAIN: begin
        if (r_resValid && bus.res_ready) begin
          if (r_row == C_LAST_ROW) begin
            w_stateNext = DONE;
            w_rowNext   = '0;
          end else begin
            w_rowNext = r_row + RW'(1);
          end
        end
      end
      DONE: begin
        w_stateNext = IDLE;
      end
      default: begin
        w_stateNext = IDLE;
      end
    endcase
  end

  // Lanes look at next-cycle t so their registered outputs line up with the feed counter.
  for (genvar gi = 0; gi < N; gi++) begin : g_lane
    systolic_skew_lane #(
      .KW  (KW),
      .TW  (TW),
      .LANE(gi)
    ) u_aLane (
      .i_t    (w_tNext),
      .i_k    (r_k),
      .i_en   (w_feedNext),
      .o_valid(w_aValid[gi]),
      .o_addr (w_aAddr[gi*KW +: KW])
    );

    systolic_skew_lane #(
      .KW  (KW),
      .TW  (TW),
      .LANE(gi)
    ) u_bLane (
      .i_t    (w_tNext),
      .i_k    (r_k),
      .i_en   (w_feedNext),
      .o_valid(w_bValid[gi]),
      .o_addr (w_bAddr[gi*KW +: KW])
    );
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state    <= IDLE;
      r_k        <= '0;
      r_t        <= '0;
      r_row      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_arrRstn  <= 1'b0;
      r_peEn     <= 1'b0;
      r_resValid <= 1'b0;
      r_aValid   <= '0;
      r_bValid   <= '0;
      r_aAddr    <= '0;
      r_bAddr    <= '0;
    end else begin
      r_state    <= w_stateNext;
      r_k        <= w_kNext;
      r_t        <= w_tNext;
      r_row      <= w_rowNext;
      r_busy     <= (w_stateNext == CLEAR) || w_feedNext || (w_stateNext == DRAIN);
      r_done     <= (w_stateNext == DONE);
      r_err      <= w_errNext;
      r_arrRstn  <= (w_stateNext != CLEAR);
      r_peEn     <= w_feedNext;
      r_resValid <= (w_stateNext == DRAIN);
      r_aValid   <= w_aValid;
      r_bValid   <= w_bValid;
      r_aAddr    <= w_aAddr;
      r_bAddr    <= w_bAddr;
    end
  end

  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.err       = r_err;
  assign bus.arr_rstn  = r_arrRstn;
  assign bus.pe_en     = r_peEn;
  assign bus.a_valid   = r_aValid;
  assign bus.a_addr    = r_aAddr;
  assign bus.b_valid   = r_bValid;
  assign bus.b_addr    = r_bAddr;
  assign bus.res_row   = r_row;
  assign bus.res_valid = r_resValid;

endmodule

// File: tb/tb_systolic_ctrl.sv
// Directed bench for systolic_ctrl (N=4, KMAX=16): timing, lane skew, stall, errors, reset.
module tb_systolic_ctrl;
  localparam int N    = 4;
  localparam int KMAX = 16;
  localparam int KW   = 4;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  int   errors  = 0;
  int   checks  = 0;
  int   doneCnt = 0;

  systolic_ctrl_if #(.N(N), .KMAX(KMAX)) bus ();

  systolic_ctrl #(.N(N), .KMAX(KMAX)) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic s, input logic [KW:0] k, input logic rdy);
    bus.start     = s;
    bus.k_len     = k;
    bus.res_ready = rdy;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, " arr_rstn"}, 32'(bus.arr_rstn), 0);
    checkOutput({tag, " busy"}, 32'(bus.busy), 0);
    checkOutput({tag, " done"}, 32'(bus.done), 0);
    checkOutput({tag, " err"}, 32'(bus.err), 0);
    checkOutput({tag, " pe_en"}, 32'(bus.pe_en), 0);
    checkOutput({tag, " res_valid"}, 32'(bus.res_valid), 0);
    checkOutput({tag, " res_row"}, 32'(bus.res_row), 0);
    checkOutput({tag, " a_valid"}, 32'(bus.a_valid), 0);
    checkOutput({tag, " a_addr"}, 32'(bus.a_addr), 0);
    checkOutput({tag, " b_valid"}, 32'(bus.b_valid), 0);
    checkOutput({tag, " b_addr"}, 32'(bus.b_addr), 0);
  endtask

  initial begin
    applyStimulus(1'b0, '0, 1'b1);
    rstn = 1'b0;
    tick();
    tick();
    checkResetOutputs("reset");
    rstn = 1'b1;
    tick();
    checkOutput("idle arr_rstn", 32'(bus.arr_rstn), 1);

    // Job 1: K=3, F=9, ready held high; lanes a[2] and b[0] tracked.
    applyStimulus(1'b1, 5'd3, 1'b1);
    checkOutput("job1 busy c0", 32'(bus.busy), 0);
    tick();
    applyStimulus(1'b0, 5'd3, 1'b1);
    for (int c = 1; c <= 16; c++) begin
      checkOutput($sformatf("job1 arr_rstn c%0d", c), 32'(bus.arr_rstn), 32'(c != 1));
      checkOutput($sformatf("job1 pe_en c%0d", c), 32'(bus.pe_en), 32'(c >= 2 && c <= 10));
      checkOutput($sformatf("job1 busy c%0d", c), 32'(bus.busy), 32'(c >= 1 && c <= 14));
      checkOutput($sformatf("job1 res_valid c%0d", c), 32'(bus.res_valid), 32'(c >= 11 && c <= 14));
      checkOutput($sformatf("job1 res_row c%0d", c), 32'(bus.res_row),
                  (c >= 11 && c <= 14) ? 32'(c - 11) : 0);
      checkOutput($sformatf("job1 done c%0d", c), 32'(bus.done), 32'(c == 15));
      checkOutput($sformatf("job1 err c%0d", c), 32'(bus.err), 0);
      checkOutput($sformatf("job1 a_valid2 c%0d", c), 32'(bus.a_valid[2]), 32'(c >= 4 && c <= 6));
      checkOutput($sformatf("job1 a_addr2 c%0d", c), 32'(bus.a_addr[2*KW +: KW]),
                  (c >= 4 && c <= 6) ? 32'(c - 4) : 0);
      checkOutput($sformatf("job1 b_valid0 c%0d", c), 32'(bus.b_valid[0]), 32'(c >= 2 && c <= 4));
      checkOutput($sformatf("job1 b_addr0 c%0d", c), 32'(bus.b_addr[0 +: KW]),
                  (c >= 2 && c <= 4) ? 32'(c - 2) : 0);
      tick();
    end

    // Job 2: K=3 with res_ready low on cycles 12..14 while row 1 is presented.
    applyStimulus(1'b1, 5'd3, 1'b1);
    tick();
    applyStimulus(1'b0, 5'd3, 1'b1);
    doneCnt = 0;
    for (int c = 1; c <= 19; c++) begin
      bus.res_ready = !(c >= 12 && c <= 14);
      checkOutput($sformatf("stall res_row c%0d", c), 32'(bus.res_row),
                  (c == 11) ? 0 : (c >= 12 && c <= 15) ? 1 : (c == 16) ? 2 : (c == 17) ? 3 : 0);
      checkOutput($sformatf("stall res_valid c%0d", c), 32'(bus.res_valid), 32'(c >= 11 && c <= 17));
      checkOutput($sformatf("stall pe_en c%0d", c), 32'(bus.pe_en), 32'(c >= 2 && c <= 10));
      checkOutput($sformatf("stall done c%0d", c), 32'(bus.done), 32'(c == 18));
      if (bus.done === 1'b1) doneCnt++;
      tick();
    end
    checkOutput("stall done count", 32'(doneCnt), 1);
    bus.res_ready = 1'b1;

    // Rejected starts: K=0 and K=KMAX+1.
    applyStimulus(1'b1, 5'd0, 1'b1);
    tick();
    applyStimulus(1'b0, 5'd0, 1'b1);
    checkOutput("k0 err", 32'(bus.err), 1);
    checkOutput("k0 busy", 32'(bus.busy), 0);
    tick();
    checkOutput("k0 err clear", 32'(bus.err), 0);
    checkOutput("k0 busy after", 32'(bus.busy), 0);
    applyStimulus(1'b1, 5'd17, 1'b1);
    tick();
    applyStimulus(1'b0, 5'd17, 1'b1);
    checkOutput("k17 err", 32'(bus.err), 1);
    checkOutput("k17 busy", 32'(bus.busy), 0);
    checkOutput("k17 arr_rstn", 32'(bus.arr_rstn), 1);
    tick();
    checkOutput("k17 err clear", 32'(bus.err), 0);
    checkOutput("k17 pe_en", 32'(bus.pe_en), 0);

    // Job 3: K=KMAX (F=22) with a stray start pulse during FEED at cycle 5.
    applyStimulus(1'b1, 5'd16, 1'b1);
    tick();
    applyStimulus(1'b0, 5'd16, 1'b1);
    doneCnt = 0;
    for (int c = 1; c <= 30; c++) begin
      if (c == 5) applyStimulus(1'b1, 5'd5, 1'b1);
      if (c == 6) applyStimulus(1'b0, 5'd5, 1'b1);
      checkOutput($sformatf("kmax pe_en c%0d", c), 32'(bus.pe_en), 32'(c >= 2 && c <= 23));
      checkOutput($sformatf("kmax done c%0d", c), 32'(bus.done), 32'(c == 28));
      checkOutput($sformatf("kmax err c%0d", c), 32'(bus.err), 0);
      if (bus.done === 1'b1) doneCnt++;
      if (c == 17) begin
        checkOutput("kmax a_valid0 t15", 32'(bus.a_valid[0]), 1);
        checkOutput("kmax a_addr0 t15", 32'(bus.a_addr[0 +: KW]), 15);
      end
      if (c == 18) checkOutput("kmax a_valid0 t16", 32'(bus.a_valid[0]), 0);
      if (c == 20) begin
        checkOutput("kmax b_valid3 t18", 32'(bus.b_valid[3]), 1);
        checkOutput("kmax b_addr3 t18", 32'(bus.b_addr[3*KW +: KW]), 15);
      end
      if (c == 21) checkOutput("kmax b_valid3 t19", 32'(bus.b_valid[3]), 0);
      tick();
    end
    checkOutput("kmax done count", 32'(doneCnt), 1);

    // Job 4: K=1 (F=7).
    applyStimulus(1'b1, 5'd1, 1'b1);
    tick();
    applyStimulus(1'b0, 5'd1, 1'b1);
    for (int c = 1; c <= 14; c++) begin
      checkOutput($sformatf("k1 pe_en c%0d", c), 32'(bus.pe_en), 32'(c >= 2 && c <= 8));
      checkOutput($sformatf("k1 done c%0d", c), 32'(bus.done), 32'(c == 13));
      checkOutput($sformatf("k1 a_valid c%0d", c), 32'(bus.a_valid),
                  (c == 2) ? 32'h1 : (c == 3) ? 32'h2 : (c == 4) ? 32'h4 : (c == 5) ? 32'h8 : 0);
      tick();
    end

    // Job 5: reset at FEED t=4, then a fresh K=2 job (F=8).
    applyStimulus(1'b1, 5'd3, 1'b1);
    tick();
    applyStimulus(1'b0, 5'd3, 1'b1);
    repeat (5) tick();
    checkOutput("midrst pe_en t4", 32'(bus.pe_en), 1);
    checkOutput("midrst a_valid t4", 32'(bus.a_valid), 32'hC);
    rstn = 1'b0;
    tick();
    checkResetOutputs("midrst");
    rstn = 1'b1;
    tick();
    checkOutput("midrst idle arr_rstn", 32'(bus.arr_rstn), 1);
    checkOutput("midrst idle pe_en", 32'(bus.pe_en), 0);
    applyStimulus(1'b1, 5'd2, 1'b1);
    tick();
    applyStimulus(1'b0, 5'd2, 1'b1);
    for (int c = 1; c <= 15; c++) begin
      checkOutput($sformatf("rerun arr_rstn c%0d", c), 32'(bus.arr_rstn), 32'(c != 1));
      checkOutput($sformatf("rerun busy c%0d", c), 32'(bus.busy), 32'(c >= 1 && c <= 13));
      checkOutput($sformatf("rerun done c%0d", c), 32'(bus.done), 32'(c == 14));
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
